// File: rtl/pe_row_feeder.sv
// pe_row_feeder: latches X, streams each matrix row into one PE as WCOUNT-nibble beats, returns 14-bit row sums.
// Build option PE_ROW_FEEDER_HHASH_EN: res_data carries only the HeavyHash nibble pe_out[13:10].
module pe_row_feeder #(
  parameter int WCOUNT  = 4,
  parameter int NWORDS  = 64,
  parameter int NROWS   = 64,
  parameter int CLR_CYC = 2,
  parameter int PE_LAT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       start_ready,
  input  logic [NWORDS*4-1:0]        x_vec,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic [WCOUNT*4-1:0]        m_data,
  output logic                       pe_en,
  output logic                       pe_clr,
  output logic [WCOUNT*4-1:0]        pe_M,
  output logic [WCOUNT*4-1:0]        pe_X,
  input  logic [13:0]                pe_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [13:0]                res_data,
  output logic [$clog2(NROWS)-1:0]   res_row,
  output logic                       done
);

  localparam int NB   = NWORDS / WCOUNT;
  localparam int KW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW   = $clog2(NROWS);
  localparam int CMAX = (CLR_CYC > PE_LAT) ? CLR_CYC : PE_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t                       state, state_nxt;
  logic [NB-1:0][WCOUNT*4-1:0]  x_reg;
  logic [KW-1:0]                k;
  logic [CW-1:0]                cnt;
  logic [RW-1:0]                row;
  logic [13:0]                  captured;

  wire clr_last   = (cnt == CW'(CLR_CYC - 1));
  wire drain_last = (cnt == CW'(PE_LAT - 1));
  wire k_last     = (k == KW'(NB - 1));
  wire row_last   = (row == RW'(NROWS - 1));

`ifdef PE_ROW_FEEDER_HHASH_EN
  assign captured = {10'd0, pe_out[13:10]};
`else
  assign captured = pe_out;
`endif

  assign res_row = row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      x_reg    <= '0;
      k        <= '0;
      cnt      <= '0;
      row      <= '0;
      res_data <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_OUTPUT) && res_ready && row_last;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg <= x_vec;
            row   <= '0;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          k   <= '0;
          cnt <= clr_last ? '0 : cnt + 1'b1;
        end
        S_FEED: begin
          if (m_valid) k <= k + 1'b1;
        end
        S_DRAIN: begin
          cnt <= drain_last ? '0 : cnt + 1'b1;
          if (drain_last) res_data <= captured;
        end
        S_OUTPUT: begin
          if (res_ready && !row_last) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall beats still assert pe_en with zero operands so the PE accumulates a zero product.
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    m_ready     = 1'b0;
    pe_en       = 1'b0;
    pe_clr      = 1'b0;
    pe_M        = '0;
    pe_X        = '0;
    res_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        pe_clr = 1'b1;
        if (clr_last) state_nxt = S_FEED;
      end
      S_FEED: begin
        m_ready = 1'b1;
        pe_en   = 1'b1;
        if (m_valid) begin
          pe_M = m_data;
          pe_X = x_reg[k];
          if (k_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pe_en = 1'b1;
        if (drain_last) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = row_last ? S_IDLE : S_CLEAR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Bench for pe_row_feeder: a behavioural PE plus a dot-product reference checks every row result and beat.
module tb_pe_row_feeder;
  localparam int WCOUNT  = 4;
  localparam int NWORDS  = 64;
  localparam int NROWS   = 64;
  localparam int CLR_CYC = 2;
  localparam int PE_LAT  = 4;
  localparam int NB      = NWORDS / WCOUNT;
  localparam int RW      = $clog2(NROWS);
  localparam int ROW_CYC = CLR_CYC + NB + PE_LAT + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 start_ready;
  logic [NWORDS*4-1:0]  x_vec = '0;
  logic                 m_valid = 1'b0;
  logic                 m_ready;
  logic [WCOUNT*4-1:0]  m_data = '0;
  logic                 pe_en, pe_clr;
  logic [WCOUNT*4-1:0]  pe_M, pe_X;
  logic [13:0]          pe_out;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [13:0]          res_data;
  logic [RW-1:0]        res_row;
  logic                 done;

  pe_row_feeder #(.WCOUNT(WCOUNT), .NWORDS(NWORDS), .NROWS(NROWS), .CLR_CYC(CLR_CYC), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .x_vec(x_vec),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .pe_en(pe_en), .pe_clr(pe_clr), .pe_M(pe_M), .pe_X(pe_X), .pe_out(pe_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row), .done(done)
  );

  always #5 clk = ~clk;

  // PE model: accumulator plus three delay stages gives a 4-cycle last-beat-to-pe_out latency.
  logic [13:0] acc, p1, p2, p3;
  assign pe_out = p3;

  function automatic logic [13:0] dot(input logic [WCOUNT*4-1:0] a, input logic [WCOUNT*4-1:0] b);
    logic [13:0] s;
    s = '0;
    for (int j = 0; j < WCOUNT; j++) s += 14'(a[4*j +: 4]) * 14'(b[4*j +: 4]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      if (pe_clr) acc <= '0;
      else if (pe_en) acc <= acc + dot(pe_M, pe_X);
      p1 <= acc; p2 <= p1; p3 <= p2;
    end
  end

  int xx [NWORDS];
  int mm [NROWS][NWORDS];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ref_row(input int r);
    int s;
    s = 0;
    for (int i = 0; i < NWORDS; i++) s += xx[i] * mm[r][i];
`ifdef PE_ROW_FEEDER_HHASH_EN
    return 14'((s >> 10) & 15);
`else
    return 14'(s);
`endif
  endfunction

  task automatic set_pattern(input int mode);
    for (int i = 0; i < NWORDS; i++)
      xx[i] = (mode == 0) ? 1 : (mode == 1) ? 15 : (mode == 2) ? i % 16 : int'($urandom_range(15));
    for (int r = 0; r < NROWS; r++)
      for (int i = 0; i < NWORDS; i++)
        mm[r][i] = (mode == 0) ? 1 : (mode == 1) ? 15 : (mode == 2) ? int'(i == r) : int'($urandom_range(15));
  endtask

  function automatic logic [NWORDS*4-1:0] pack_x();
    logic [NWORDS*4-1:0] v;
    for (int i = 0; i < NWORDS; i++) v[4*i +: 4] = 4'(xx[i]);
    return v;
  endfunction

  function automatic logic [WCOUNT*4-1:0] beat_m(input int r, input int k);
    logic [WCOUNT*4-1:0] v;
    v = '0;
    if (r < NROWS) for (int j = 0; j < WCOUNT; j++) v[4*j +: 4] = 4'(mm[r][k*WCOUNT + j]);
    return v;
  endfunction

  function automatic logic [WCOUNT*4-1:0] slice_x(input int k);
    logic [WCOUNT*4-1:0] v;
    for (int j = 0; j < WCOUNT; j++) v[4*j +: 4] = 4'(xx[k*WCOUNT + j]);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, start_ready, 1);
    check({tag, "_m_ready"}, m_ready, 0);
    check({tag, "_pe_en"}, pe_en, 0);
    check({tag, "_pe_clr"}, pe_clr, 0);
    check({tag, "_pe_M"}, pe_M, 0);
    check({tag, "_pe_X"}, pe_X, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_row"}, res_row, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_job(input int stall_pct, input int hold, input int abort_row, input bit poke);
    int rr = 0, kk = 0, rows_seen = 0, cyc = 0, last_hs = 0, wait_cnt = 0;
    bit prev_hold = 1'b0, fin = 1'b0, hs;
    logic [13:0] prev_data = '0;
    logic [RW-1:0] prev_row = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; m_valid = 1'b1; m_data = '1; res_ready = 1'b1;
      #1;
      check("idle_m_ready", m_ready, 0);
      check("idle_start_ready", start_ready, 1);
      check("idle_done", done, 0);
    end
    @(negedge clk);
    x_vec = pack_x(); start = 1'b1;
    #1;
    check("start_accept", start_ready, 1);
    while (!fin && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && rows_seen < NROWS - 1 && $urandom_range(9) == 0) begin
        start = 1'b1; x_vec = ~x_vec;
      end
      m_valid = (int'($urandom_range(99)) >= stall_pct);
      m_data = beat_m(rr, kk);
      res_ready = (wait_cnt >= hold);
      #1;
      if (prev_hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, prev_data);
        check("hold_row", res_row, prev_row);
      end
      if (pe_clr === 1'b1 || pe_en === 1'b1 || res_valid === 1'b1) check("busy_start_ready", start_ready, 0);
      if (pe_clr === 1'b1) begin
        check("clr_m_ready", m_ready, 0);
        check("clr_pe_en", pe_en, 0);
        check("clr_ops", {pe_M, pe_X}, 0);
      end
      if (m_ready === 1'b1) begin
        check("feed_pe_en", pe_en, 1);
        if (m_valid) begin
          check("beat_pe_M", pe_M, beat_m(rr, kk));
          check("beat_pe_X", pe_X, slice_x(kk));
          kk++;
          if (kk == NB) begin kk = 0; rr++; end
        end else begin
          check("stall_ops", {pe_M, pe_X}, 0);
        end
      end
      if (abort_row >= 0 && rr == abort_row && kk == 3) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0; m_valid = 1'b0;
        return;
      end
      hs = (res_valid === 1'b1) && res_ready;
      if (hs) begin
        check("res_row", res_row, rows_seen);
        check("res_data", res_data, ref_row(rows_seen));
        if (stall_pct == 0 && hold == 0) check("row_cycles", cyc - last_hs, ROW_CYC);
        last_hs = cyc; rows_seen++; wait_cnt = 0;
      end else if (res_valid === 1'b1) begin
        wait_cnt++;
      end
      prev_hold = (res_valid === 1'b1) && !res_ready;
      prev_data = res_data; prev_row = res_row;
      check("done", done, (rows_seen == NROWS) && (cyc == last_hs + 1));
      if (rows_seen == NROWS && cyc == last_hs + 1) fin = 1'b1;
    end
    check("job_finished", fin, 1);
    check("rows_returned", rows_seen, NROWS);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_pattern(0); run_job(0, 0, -1, 1'b0);
    set_pattern(1); run_job(0, 0, -1, 1'b0);
    set_pattern(2); run_job(0, 0, -1, 1'b0);
    set_pattern(0); run_job(50, 10, -1, 1'b0);
    set_pattern(3); run_job(50, 10, -1, 1'b1);
    set_pattern(0); run_job(30, 0, 5, 1'b0);
    run_job(0, 0, -1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
